// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one asynchronous SRAM between an instruction-fetch port (I, read-only) and a
// load/store port (D, read/write). A winning request is latched in IDLE, the strobes are
// held for ACCESS_CYCLES cycles, read data is captured on the last access edge, and the
// granted port sees a one-cycle ack in DONE.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   i_req/i_addr              fetch request and address (held until i_ack)
//   i_ack/i_rdata             fetch completion pulse and registered fetch data
//   d_req/d_we/d_addr/d_wdata load/store request, direction, address, store data
//   d_ack/d_rdata             load/store completion pulse and registered load data
//   mem_cs/mem_oe/mem_we      SRAM strobes, active high
//   mem_addr/mem_din/mem_dout SRAM address, write data, read data
//   busy                      high while an access is in ACCESS or DONE
//
// Build option:
//   SRAM_ARB_ROUND_ROBIN_EN   defined: on simultaneous requests the port not granted last
//                             wins; undefined: fixed priority, D over I.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  // A window of zero cycles is meaningless; clamp to one.
  localparam int unsigned AccCycles = (ACCESS_CYCLES == 0) ? 1 : ACCESS_CYCLES;
  localparam int unsigned CntW      = (AccCycles > 1) ? $clog2(AccCycles) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(AccCycles - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [CntW-1:0]   r_cnt;
  logic              r_we;
  logic              r_gnt_d;     // 1: D owns the current/last transaction
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_start;
  logic              w_grant_d;
  logic              w_last_access;
  logic              w_capture;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // r_gnt_d is only rewritten on a grant and resets to I, so it doubles as the
  // last-grant pointer.
  always_comb begin
    w_grant_d = d_req & (~i_req | ~r_gnt_d);
  end
`else
  always_comb begin
    w_grant_d = d_req;
  end
`endif

  always_comb begin
    w_start       = (r_state == StIdle) && (i_req || d_req);
    w_last_access = (r_state == StAccess) && (r_cnt == '0);
    w_capture     = w_last_access && !r_we;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (i_req || d_req) begin
          w_state_next = StAccess;
        end
      end
      StAccess: begin
        if (r_cnt == '0) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_cs = 1'b0;
    mem_oe = 1'b0;
    mem_we = 1'b0;
    i_ack  = 1'b0;
    d_ack  = 1'b0;
    busy   = 1'b0;
    case (r_state)
      StAccess: begin
        mem_cs = 1'b1;
        mem_oe = ~r_we;
        mem_we = r_we;
        busy   = 1'b1;
      end
      StDone: begin
        i_ack = ~r_gnt_d;
        d_ack = r_gnt_d;
        busy  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch, access counter and read-data capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_gnt_d   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_start) begin
        r_cnt   <= CntLoad;
        r_gnt_d <= w_grant_d;
        r_we    <= w_grant_d & d_we;
        r_addr  <= w_grant_d ? d_addr : i_addr;
        // Fetches carry no data; keep mem_din at the last store value.
        if (w_grant_d) begin
          r_wdata <= d_wdata;
        end
      end else if ((r_state == StAccess) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_capture) begin
        if (r_gnt_d) begin
          r_d_rdata <= mem_dout;
        end else begin
          r_i_rdata <= mem_dout;
        end
      end
    end
  end

  assign mem_addr = r_addr;
  assign mem_din  = r_wdata;
  assign i_rdata  = r_i_rdata;
  assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter. Two instances share one set of stimulus signals:
// u_dut2 (ACCESS_CYCLES=2) and u_dut4 (ACCESS_CYCLES=4); 'sel' routes requests to one
// of them and picks which one is observed. Each instance has its own SRAM model.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic sel;

  logic        tb_i_req, tb_d_req, tb_d_we;
  logic [31:0] tb_i_addr, tb_d_addr, tb_d_wdata;

  logic        i_ack2, d_ack2, cs2, oe2, we2, busy2;
  logic [31:0] i_rdata2, d_rdata2, addr2, din2, dout2;
  logic        i_ack4, d_ack4, cs4, oe4, we4, busy4;
  logic [31:0] i_rdata4, d_rdata4, addr4, din4, dout4;

  logic        pl_en;
  logic [31:0] pl_addr, pl_data;
  logic [31:0] m2 [1024];
  logic [31:0] m4 [1024];

  int n_vec, n_err;
  int o_icyc, o_dcyc, o_ncs, o_nwe, o_noe, o_nacks;
  logic both_seen = 1'b0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ACCESS_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .i_req(tb_i_req & ~sel), .i_addr(tb_i_addr), .i_ack(i_ack2), .i_rdata(i_rdata2),
    .d_req(tb_d_req & ~sel), .d_we(tb_d_we), .d_addr(tb_d_addr), .d_wdata(tb_d_wdata),
    .d_ack(d_ack2), .d_rdata(d_rdata2),
    .mem_cs(cs2), .mem_oe(oe2), .mem_we(we2), .mem_addr(addr2), .mem_din(din2),
    .mem_dout(dout2), .busy(busy2)
  );

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ACCESS_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .i_req(tb_i_req & sel), .i_addr(tb_i_addr), .i_ack(i_ack4), .i_rdata(i_rdata4),
    .d_req(tb_d_req & sel), .d_we(tb_d_we), .d_addr(tb_d_addr), .d_wdata(tb_d_wdata),
    .d_ack(d_ack4), .d_rdata(d_rdata4),
    .mem_cs(cs4), .mem_oe(oe4), .mem_we(we4), .mem_addr(addr4), .mem_din(din4),
    .mem_dout(dout4), .busy(busy4)
  );

  // Asynchronous SRAM models: combinational read, write committed while cs & we.
  assign dout2 = m2[addr2[11:2]];
  assign dout4 = m4[addr4[11:2]];

  always @(posedge clk) begin
    if (pl_en) m2[pl_addr[11:2]] <= pl_data;
    else if (cs2 && we2) m2[addr2[11:2]] <= din2;
  end

  always @(posedge clk) begin
    if (pl_en) m4[pl_addr[11:2]] <= pl_data;
    else if (cs4 && we4) m4[addr4[11:2]] <= din4;
  end

  always @(negedge clk) begin
    if ((oe2 && we2) || (oe4 && we4)) both_seen <= 1'b1;
  end

  wire        obs_i_ack   = sel ? i_ack4   : i_ack2;
  wire        obs_d_ack   = sel ? d_ack4   : d_ack2;
  wire        obs_cs      = sel ? cs4      : cs2;
  wire        obs_oe      = sel ? oe4      : oe2;
  wire        obs_we      = sel ? we4      : we2;
  wire        obs_busy    = sel ? busy4    : busy2;
  wire [31:0] obs_i_rdata = sel ? i_rdata4 : i_rdata2;
  wire [31:0] obs_d_rdata = sel ? d_rdata4 : d_rdata2;
  wire [31:0] obs_addr    = sel ? addr4    : addr2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue up to one request per port from IDLE, act as a well-behaved requester (drop req on
  // its ack) and record ack cycles relative to the sampling edge plus strobe counts.
  task automatic run_txn(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
    int  k;
    logic pend_i, pend_d;
    o_icyc = 0; o_dcyc = 0; o_ncs = 0; o_nwe = 0; o_noe = 0; o_nacks = 0;
    @(negedge clk);
    tb_i_req = ir; tb_i_addr = ia;
    tb_d_req = dr; tb_d_we = dwe; tb_d_addr = da; tb_d_wdata = dwd;
    pend_i = ir; pend_d = dr; k = 0;
    while ((pend_i || pend_d) && k < 30) begin
      @(posedge clk); #1; k++;
      if (obs_cs) o_ncs++;
      if (obs_we) o_nwe++;
      if (obs_oe) o_noe++;
      if (obs_i_ack) begin
        o_nacks++; if (o_icyc == 0) o_icyc = k; tb_i_req = 1'b0; pend_i = 1'b0;
      end
      if (obs_d_ack) begin
        o_nacks++; if (o_dcyc == 0) o_dcyc = k; tb_d_req = 1'b0; pend_d = 1'b0;
      end
    end
    tb_i_req = 1'b0; tb_d_req = 1'b0;
    // DONE -> IDLE edge; acks must already be gone.
    @(posedge clk); #1;
    if (obs_i_ack || obs_d_ack) o_nacks++;
    if (obs_cs) o_ncs++;
  endtask

  task automatic check_res(input string tag, input int e_icyc, input int e_dcyc,
                           input int e_nwe, input int e_noe,
                           input logic [31:0] e_ird, input logic [31:0] e_drd);
    chk($sformatf("%s_i_ack_cycle", tag), o_icyc, e_icyc);
    chk($sformatf("%s_d_ack_cycle", tag), o_dcyc, e_dcyc);
    chk($sformatf("%s_we_cycles", tag), o_nwe, e_nwe);
    chk($sformatf("%s_oe_cycles", tag), o_noe, e_noe);
    chk($sformatf("%s_cs_cycles", tag), o_ncs, e_nwe + e_noe);
    chk($sformatf("%s_ack_count", tag), o_nacks, ((e_icyc != 0) ? 1 : 0) + ((e_dcyc != 0) ? 1 : 0));
    chk($sformatf("%s_i_rdata", tag), obs_i_rdata, e_ird);
    chk($sformatf("%s_d_rdata", tag), obs_d_rdata, e_drd);
  endtask

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    int          icyc;
    int          dcyc;
    int          nwe;
    int          noe;
    logic [31:0] ird;
    logic [31:0] drd;
  } vec_t;

  vec_t        tbl [5];
  logic [31:0] baddr [3];
  logic [31:0] bexp [3];
  logic [31:0] mdl [16];

  initial begin
    int          n, k, spurious;
    logic        ir, dr, dwe, d_first, last_d;
    logic [3:0]  ja, jd;
    logic [31:0] wd, ia, da, exp_i, exp_d;
    int          e_icyc, e_dcyc, e_nwe, e_noe;

    n_vec = 0; n_err = 0;
    sel = 1'b0; rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    tb_i_req = 1'b0; tb_d_req = 1'b0; tb_d_we = 1'b0;
    tb_i_addr = '0; tb_d_addr = '0; tb_d_wdata = '0;

    // Preload while reset is held.
    preload(32'h0000_0000, 32'h1111_1111);
    preload(32'h0000_0004, 32'h8C22_0000);
    preload(32'h0000_0008, 32'h2222_2222);
    preload(32'h0000_0200, 32'h3333_3333);
    for (int j = 0; j < 16; j++) begin
      mdl[j] = 32'hA500_0000 | 32'(j);
      preload(32'h300 + 32'(j) * 4, mdl[j]);
    end

    // Reset state
    @(negedge clk);
    chk("rst_mem_cs", 32'(obs_cs), 0);
    chk("rst_mem_oe", 32'(obs_oe), 0);
    chk("rst_mem_we", 32'(obs_we), 0);
    chk("rst_busy", 32'(obs_busy), 0);
    chk("rst_i_ack", 32'(obs_i_ack), 0);
    chk("rst_d_ack", 32'(obs_d_ack), 0);
    chk("rst_i_rdata", obs_i_rdata, 0);
    chk("rst_d_rdata", obs_d_rdata, 0);
    chk("rst_mem_addr", obs_addr, 0);
    rst = 1'b0;

    // Directed table (ACCESS_CYCLES = 2)
    //            ir    ia        dr    dwe   da        dwd            icyc dcyc nwe noe ird drd
    tbl[0] = '{1'b1, 32'h4,   1'b0, 1'b0, 32'h0,   32'h0,          3, 0, 0, 2,
               32'h8C22_0000, 32'h0};
    tbl[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF,  0, 3, 2, 0,
               32'h8C22_0000, 32'h0};
    tbl[2] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h100, 32'h0,          0, 3, 0, 2,
               32'h8C22_0000, 32'hDEAD_BEEF};
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // Last grant was D, so I wins the tie; then D, so I wins again.
    tbl[3] = '{1'b1, 32'h8,   1'b1, 1'b0, 32'h200, 32'h0,          3, 7, 0, 4,
               32'h2222_2222, 32'h3333_3333};
    tbl[4] = '{1'b1, 32'h0,   1'b1, 1'b1, 32'h0,   32'h55AA_55AA,  3, 7, 2, 2,
               32'h1111_1111, 32'h3333_3333};
`else
    tbl[3] = '{1'b1, 32'h8,   1'b1, 1'b0, 32'h200, 32'h0,          7, 3, 0, 4,
               32'h2222_2222, 32'h3333_3333};
    tbl[4] = '{1'b1, 32'h0,   1'b1, 1'b1, 32'h0,   32'h55AA_55AA,  7, 3, 2, 2,
               32'h55AA_55AA, 32'h3333_3333};
`endif
    for (int v = 0; v < 5; v++) begin
      run_txn(tbl[v].ir, tbl[v].ia, tbl[v].dr, tbl[v].dwe, tbl[v].da, tbl[v].dwd);
      check_res($sformatf("tbl%0d", v), tbl[v].icyc, tbl[v].dcyc, tbl[v].nwe, tbl[v].noe,
                tbl[v].ird, tbl[v].drd);
    end

    // Back-to-back fetches with i_req held high throughout
    baddr[0] = 32'h0; baddr[1] = 32'h4; baddr[2] = 32'h8;
    bexp[0] = 32'h55AA_55AA; bexp[1] = 32'h8C22_0000; bexp[2] = 32'h2222_2222;
    @(negedge clk);
    tb_i_req = 1'b1; tb_i_addr = baddr[0];
    n = 0; k = 0;
    while (n < 3 && k < 20) begin
      @(posedge clk); #1; k++;
      if (obs_i_ack) begin
        chk($sformatf("b2b%0d_ack_cycle", n), k, 4 * n + 3);
        chk($sformatf("b2b%0d_i_rdata", n), obs_i_rdata, bexp[n]);
        n++;
        if (n < 3) tb_i_addr = baddr[n];
        else tb_i_req = 1'b0;
      end
    end
    tb_i_req = 1'b0;
    chk("b2b_ack_count", n, 3);
    @(posedge clk); #1;

    // Reset in the second ACCESS cycle of a read
    @(negedge clk);
    tb_i_req = 1'b1; tb_i_addr = 32'h8;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstmid_pre_cs", 32'(obs_cs), 1);
    chk("rstmid_pre_busy", 32'(obs_busy), 1);
    rst = 1'b1; tb_i_req = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_cs", 32'(obs_cs), 0);
    chk("rstmid_busy", 32'(obs_busy), 0);
    chk("rstmid_i_ack", 32'(obs_i_ack), 0);
    chk("rstmid_i_rdata", obs_i_rdata, 0);
    rst = 1'b0;
    spurious = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (obs_i_ack || obs_d_ack || obs_cs) spurious++;
    end
    chk("rstmid_quiet_after", spurious, 0);
    run_txn(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    check_res("rstmid_reissue", 3, 0, 0, 2, 32'h2222_2222, 32'h0);

    // Randomised transactions against a transaction-level model
    exp_i = 32'h2222_2222; exp_d = 32'h0; last_d = 1'b0;
    for (int t = 0; t < 40; t++) begin
      ir  = 1'($urandom_range(0, 1));
      dr  = 1'($urandom_range(0, 1));
      if (!ir && !dr) ir = 1'b1;
      dwe = 1'($urandom_range(0, 1));
      ja  = 4'($urandom_range(0, 15));
      jd  = 4'($urandom_range(0, 15));
      wd  = $urandom();
      ia  = 32'h300 + 32'(ja) * 4;
      da  = 32'h300 + 32'(jd) * 4;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      d_first = dr && (!ir || !last_d);
`else
      d_first = dr;
`endif
      e_icyc = 0; e_dcyc = 0;
      if (d_first) begin
        if (dwe) mdl[jd] = wd; else exp_d = mdl[jd];
        e_dcyc = 3; last_d = 1'b1;
        if (ir) begin
          exp_i = mdl[ja]; e_icyc = 7; last_d = 1'b0;
        end
      end else begin
        exp_i = mdl[ja]; e_icyc = 3; last_d = 1'b0;
        if (dr) begin
          if (dwe) mdl[jd] = wd; else exp_d = mdl[jd];
          e_dcyc = 7; last_d = 1'b1;
        end
      end
      e_nwe = (dr && dwe) ? 2 : 0;
      e_noe = (ir ? 2 : 0) + ((dr && !dwe) ? 2 : 0);
      run_txn(ir, ia, dr, dwe, da, wd);
      check_res($sformatf("rnd%0d", t), e_icyc, e_dcyc, e_nwe, e_noe, exp_i, exp_d);
    end

    // ACCESS_CYCLES = 4 instance
    @(negedge clk);
    sel = 1'b1;
    run_txn(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    check_res("acc4_iread", 5, 0, 0, 4, 32'h8C22_0000, 32'h0);
    run_txn(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h1234_5678);
    check_res("acc4_dwrite", 0, 5, 4, 0, 32'h8C22_0000, 32'h0);
    run_txn(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
    check_res("acc4_dread", 0, 5, 0, 4, 32'h8C22_0000, 32'h1234_5678);

    chk("oe_we_exclusive", 32'(both_seen), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
